// File: rtl/fir_param.sv
// fir_param: direct-form FIR, products at E+1, sum at E+2, rounded/saturated output at E+3; no backpressure.
// Optional macro FIR_ROUND_EN: round half up on the OUT_SHIFT scaling (default build truncates).
module fir_param #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 16,
  parameter int OUT_SHIFT = 0,
  localparam int AW       = $clog2(TAPS),
  localparam int ACC_W    = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     coef_we,
  input  logic        [AW-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     sat
);
  localparam int PW = DATA_W + COEF_W;
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;
`ifdef FIR_ROUND_EN
  // Half an output LSB; zero when OUT_SHIFT is 0 so both builds agree there.
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) << OUT_SHIFT >> 1;
`endif

  logic signed [DATA_W-1:0] x_q    [TAPS];
  logic signed [DATA_W-1:0] x_d    [TAPS];
  logic signed [COEF_W-1:0] c_q    [TAPS];
  logic signed [COEF_W-1:0] c_d    [TAPS];
  logic signed [PW-1:0]     prod_q [TAPS];
  logic signed [PW-1:0]     prod_d [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic signed [ACC_W:0]    z;
  logic        [2:0]        vld_q, vld_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] data_out_q, data_out_d;
  logic                     sat_q, sat_d;

  always_comb begin
    x_d = x_q;
    if (in_valid) begin
      x_d[0] = data_in;
      for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
    end

    c_d = c_q;
    if (coef_we && (int'(coef_addr) < TAPS)) c_d[coef_addr] = coef_wdata;

    // Reads registered coefficients, so a write on this edge lands after the capture.
    prod_d = prod_q;
    if (vld_q[0]) begin
      for (int k = 0; k < TAPS; k++) prod_d[k] = PW'(x_q[k]) * PW'(c_q[k]);
    end

    acc_sum = '0;
    for (int k = 0; k < TAPS; k++) acc_sum = acc_sum + ACC_W'(prod_q[k]);
    acc_d = vld_q[1] ? acc_sum : acc_q;

`ifdef FIR_ROUND_EN
    z = ((ACC_W+1)'(acc_q) + RND) >>> OUT_SHIFT;
`else
    z = (ACC_W+1)'(acc_q) >>> OUT_SHIFT;
`endif

    data_out_d = data_out_q;
    sat_d      = sat_q;
    if (vld_q[2]) begin
      if (z > MAX_V) begin
        data_out_d = MAX_V[DATA_W-1:0];
        sat_d      = 1'b1;
      end else if (z < MIN_V) begin
        data_out_d = MIN_V[DATA_W-1:0];
        sat_d      = 1'b1;
      end else begin
        data_out_d = z[DATA_W-1:0];
        sat_d      = 1'b0;
      end
    end

    vld_d       = {vld_q[1:0], in_valid};
    out_valid_d = vld_q[2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q         <= '{default: '0};
      c_q         <= '{default: '0};
      prod_q      <= '{default: '0};
      acc_q       <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      x_q         <= x_d;
      c_q         <= c_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign sat       = sat_q;
endmodule
